// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control.
// Build option MC_IMM_ALU_EN: LUI/SLTI decode to the immediate-ALU path with ALUOp=IMM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LUI  = 6'd15;
    localparam logic [5:0] OP_SLTI = 6'd10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MC_IMM_ALU_EN
    localparam bit IMM_ALU_EN = 1'b1;
`else
    localparam bit IMM_ALU_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // True for opcodes that take the immediate path with opcode-selected ALU operation.
    function automatic logic is_imm_alu(input logic [5:0] op);
        return IMM_ALU_EN && ((op == OP_LUI) || (op == OP_SLTI));
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore control-word decoder: state (plus opcode / mem_ready where needed) to datapath controls.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_IMM_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = is_imm_alu(opcode) ? ALU_IMM : ALU_ADD;
            end
            S_IMM_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and reset gating of enables.
// Build option MC_IMM_ALU_EN (see mc_ctrl_pkg) adds the LUI/SLTI immediate-ALU decode.
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int OPCODE_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [STATE_W-1:0] state_o
);

    state_t     state;
    state_t     state_next;
    logic [5:0] op;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl;

    assign op = 6'(opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_R)                        state_next = S_EXEC;
                else if (op == OP_LW || op == OP_SW)   state_next = S_MEM_ADR;
                else if (op == OP_ADDI || is_imm_alu(op)) state_next = S_IMM_EXEC;
                else if (op == OP_BEQ)                 state_next = S_BRANCH;
                else if (op == OP_J)                   state_next = S_JUMP;
                else                                   state_next = S_FETCH;
            end
            S_MEM_ADR: begin
                if (op == OP_LW)      state_next = S_MEM_RD;
                else if (op == OP_SW) state_next = S_MEM_WR;
                else                  state_next = S_FETCH;
            end
            S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_next = S_ALU_WB;
            S_IMM_EXEC: state_next = S_IMM_WB;
            default:    state_next = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .opcode    (op),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // While reset is high no enable may fire, even though FETCH would request a read.
    always_comb begin
        ctrl = ctrl_raw;
        if (rst) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.mem_read      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.reg_write     = 1'b0;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state_o       = STATE_W'(state);

endmodule

// File: tb/tb_mc_main_control.sv
// Randomized bench for mc_main_control: per-instruction state sequences checked every cycle.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    mc_main_control #(.STATE_W(4), .OPCODE_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

`ifdef MC_IMM_ALU_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int         seq[$];
    int         idx = 0;
    logic [5:0] cur_op = 6'd0;
    int         pool[8] = '{0, 35, 43, 8, 4, 2, 15, 10};

    wire [15:0] ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    endtask

    // Expected control word for one cycle in the given state.
    function automatic logic [15:0] exp_ctrl(input int st, input logic [5:0] op, input logic rdy);
        logic pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, aop, psrc;
        {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, sa} = '0;
        sb = 2'd0; aop = 2'd0; psrc = 2'd0;
        case (st)
            0:  begin mr = 1; sb = 2'd1; irw = rdy; pw = rdy; end
            1:  sb = 2'd3;
            2:  begin sa = 1; sb = 2'd2; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; aop = 2'd2; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin sa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
            9:  begin pw = 1; psrc = 2'd2; end
            10: begin sa = 1; sb = 2'd2; aop = (op == 6'd8) ? 2'd0 : 2'd3; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, psrc};
    endfunction

    // Instruction class -> ordered list of states it visits.
    task automatic start_instr(input logic [5:0] op);
        seq.delete();
        idx = 0;
        cur_op = op;
        case (op)
            6'd0:  seq = '{0, 1, 6, 7};
            6'd35: seq = '{0, 1, 2, 3, 4};
            6'd43: seq = '{0, 1, 2, 5};
            6'd8:  seq = '{0, 1, 10, 11};
            6'd4:  seq = '{0, 1, 8};
            6'd2:  seq = '{0, 1, 9};
            6'd15, 6'd10: if (IMM_EN) seq = '{0, 1, 10, 11}; else seq = '{0, 1};
            default: seq = '{0, 1};
        endcase
    endtask

    // One clock cycle: pick inputs, check outputs at negedge, advance the model.
    task automatic step(input int force_op, input int force_rdy);
        logic rdy;
        int   st;
        if (seq.size() == 0) begin
            int r;
            logic [5:0] op;
            r  = $urandom_range(0, 9);
            op = (force_op >= 0) ? 6'(force_op) : (r < 8 ? 6'(pool[r]) : 6'($urandom_range(0, 63)));
            start_instr(op);
            opcode = op;
        end
        rdy = (force_rdy >= 0) ? (force_rdy != 0) : ($urandom_range(0, 3) != 0);
        mem_ready = rdy;
        @(negedge clk);
        st = seq[idx];
        check_eq("state", 32'(state_o), 32'(st));
        check_eq($sformatf("ctrl_s%0d_op%0d", st, cur_op), 32'(ctrl_obs), 32'(exp_ctrl(st, cur_op, rdy)));
        if (!((st == 0 || st == 3 || st == 5) && !rdy)) idx++;
        if (idx >= seq.size()) begin
            seq.delete();
            idx = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_instr(input int op);
        step(op, 1);
        for (int k = 0; k < 10 && seq.size() != 0; k++) step(op, 1);
    endtask

    int lw_rdy[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", 32'(state_o), 32'd0);
        check_eq("reset_ctrl", 32'(ctrl_obs), 32'h0010);
        rst = 1'b0;

        run_instr(0);
        run_instr(4);
        run_instr(2);
        run_instr(43);
        run_instr(8);
        run_instr(15);
        run_instr(10);
        run_instr(63);
        for (int k = 0; k < 10; k++) step(35, lw_rdy[k]);

        for (int k = 0; k < 400; k++) step(-1, -1);
        for (int k = 0; k < 20 && seq.size() != 0; k++) step(-1, -1);

        // Abort a store that is stalled in MEM_WR.
        for (int k = 0; k < 10 && !(seq.size() != 0 && seq[idx] == 5); k++) step(43, 1);
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_state", 32'(state_o), 32'd5);
        check_eq("pre_rst_mem_write", 32'(mem_write), 32'd1);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_eq("rst_state", 32'(state_o), 32'd0);
        check_eq("rst_mem_write", 32'(mem_write), 32'd0);
        check_eq("rst_ctrl", 32'(ctrl_obs), 32'h0010);
        @(posedge clk);
        #1;
        check_eq("rst_hold_state", 32'(state_o), 32'd0);
        check_eq("rst_hold_ctrl", 32'(ctrl_obs), 32'h0010);
        rst = 1'b0;
        #1;
        check_eq("post_rst_mem_read", 32'(mem_read), 32'd1);
        check_eq("post_rst_state", 32'(state_o), 32'd0);
        seq.delete();
        idx = 0;
        for (int k = 0; k < 40; k++) step(-1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
